// File: rtl/mem_arb_pkg.sv
// Command codes, FSM state encoding and I/O register addresses shared by
// the mem_arbiter slice.
package mem_arb_pkg;

  localparam int unsigned CMD_W = 2;

  localparam logic [CMD_W-1:0] MNONE  = 2'b00;
  localparam logic [CMD_W-1:0] MREAD  = 2'b01;
  localparam logic [CMD_W-1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: two req/cmd/addr/wdata channels with
// per-requester grant/done and a shared read-data return.
interface mem_arbiter_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
);
  logic          r0_req;
  logic          r1_req;
  logic [1:0]    r0_cmd;
  logic [1:0]    r1_cmd;
  logic [AW-1:0] r0_addr;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r0_wdata;
  logic [DW-1:0] r1_wdata;
  logic          r0_gnt;
  logic          r1_gnt;
  logic          r0_done;
  logic          r1_done;
  logic [DW-1:0] rdata;

  modport master (
    output r0_req, r1_req, r0_cmd, r1_cmd, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  r0_gnt, r1_gnt, r0_done, r1_done, rdata
  );

  modport slave (
    input  r0_req, r1_req, r0_cmd, r1_cmd, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output r0_gnt, r1_gnt, r0_done, r1_done, rdata
  );
endinterface

// File: rtl/mem_io_regs.sv
// Memory-mapped I/O for mem_arbiter: LED register at LED_ADDR and the
// switch read mux at SW_ADDR. Only built with MEM_ARBITER_IO_EN.
module mem_io_regs
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc,
  input  logic [1:0]    cmd,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wbyte,
  input  logic [7:0]    sw,
  output logic [7:0]    ledr,
  output logic [DW-1:0] rdata_c
);

  logic led_hit_c;
  logic sw_hit_c;

  assign led_hit_c = (addr == AW'(LED_ADDR));
  assign sw_hit_c  = (addr == AW'(SW_ADDR));

  // LED register loads at the end of the access cycle of a matching write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ledr <= '0;
    end else if (acc && (cmd == MWRITE) && led_hit_c) begin
      ledr <= wbyte;
    end
  end

  assign rdata_c = ((cmd == MREAD) && sw_hit_c) ? DW'({8'h00, sw}) : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the 256x16 RAM and LED/switch I/O between two
// requesters. I/O decode is present only when MEM_ARBITER_IO_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 9,
  parameter int unsigned DW     = 16,
  parameter int unsigned RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_write,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  input  logic [7:0]        sw,
  output logic [7:0]        ledr
);

  state_t        state;
  state_t        state_nxt;
  logic          last;
  logic          owner;
  logic          ram_rd;
  logic [1:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] io_rdata_c;

  logic          any_req_c;
  logic          pick1_c;
  logic [1:0]    win_cmd_c;
  logic [AW-1:0] win_addr_c;
  logic [DW-1:0] win_wdata_c;

  // r1 wins when alone, or on a tie when r0 was granted last
  assign any_req_c   = bus.r0_req | bus.r1_req;
  assign pick1_c     = bus.r1_req & (~bus.r0_req | ~last);
  assign win_cmd_c   = pick1_c ? bus.r1_cmd   : bus.r0_cmd;
  assign win_addr_c  = pick1_c ? bus.r1_addr  : bus.r0_addr;
  assign win_wdata_c = pick1_c ? bus.r1_wdata : bus.r0_wdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req_c) state_nxt = ACC;
      ACC:     state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Transaction latch, RAM strobes, grant/done and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last        <= 1'b1;
      owner       <= 1'b0;
      cmd_q       <= MNONE;
      addr_q      <= '0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_write   <= 1'b0;
      ram_rd      <= 1'b0;
      rdata_q     <= '0;
      bus.r0_gnt  <= 1'b0;
      bus.r1_gnt  <= 1'b0;
      bus.r0_done <= 1'b0;
      bus.r1_done <= 1'b0;
    end else begin
      ram_write   <= 1'b0;
      bus.r0_done <= 1'b0;
      bus.r1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            owner      <= pick1_c;
            last       <= pick1_c;
            cmd_q      <= win_cmd_c;
            addr_q     <= win_addr_c;
            ram_addr   <= RAM_AW'(win_addr_c);
            ram_din    <= win_wdata_c;
            ram_write  <= (win_cmd_c == MWRITE) & ~win_addr_c[AW-1];
            bus.r0_gnt <= ~pick1_c;
            bus.r1_gnt <= pick1_c;
          end
        end
        ACC: begin
          bus.r0_done <= ~owner;
          bus.r1_done <= owner;
          if (cmd_q == MREAD) begin
            ram_rd <= ~addr_q[AW-1];
            if (addr_q[AW-1]) rdata_q <= io_rdata_c;
          end
        end
        RSP: begin
          bus.r0_gnt <= 1'b0;
          bus.r1_gnt <= 1'b0;
          ram_rd     <= 1'b0;
          if (ram_rd) rdata_q <= ram_dout;
        end
        default: ;
      endcase
    end
  end

  // RAM read data arrives during RSP; pass it through then hold it in rdata_q
  assign bus.rdata = ram_rd ? ram_dout : rdata_q;

`ifdef MEM_ARBITER_IO_EN
  mem_io_regs #(
    .AW (AW),
    .DW (DW)
  ) u_io (
    .clk     (clk),
    .rst_n   (reset),
    .acc     (state == ACC),
    .cmd     (cmd_q),
    .addr    (addr_q),
    .wbyte   (ram_din[7:0]),
    .sw      (sw),
    .ledr    (ledr),
    .rdata_c (io_rdata_c)
  );
`else
  logic unused_io;
  assign unused_io  = ^{sw, addr_q[AW-2:0]};
  assign ledr       = '0;
  assign io_rdata_c = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized
// traffic from both requesters against an address-map reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW     = 9;
  localparam int unsigned DW     = 16;
  localparam int unsigned RAM_AW = 8;
`ifdef MEM_ARBITER_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_write;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_dout;
  logic [7:0]        sw;
  logic [7:0]        ledr;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .RAM_AW(RAM_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .sw        (sw),
    .ledr      (ledr)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM attached to the arbiter
  logic [15:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  typedef struct {
    logic        is_rd;
    logic        ram_wr;
    logic [7:0]  ram_a;
    logic [15:0] din;
    logic [15:0] exp_rd;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mem_model [256];
  logic [7:0]  led_model;
  logic [15:0] last_exp;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wr_cycles = 0;
  int          exp_wr = 0;
  int          done_r[$];
  int          done_c[$];
  int          l0, g0, l1, g1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: address map applied to a transaction, in program order per requester
  function automatic exp_t model(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    exp_t e;
    e.is_rd  = (cmd == MREAD);
    e.ram_wr = (cmd == MWRITE) && !addr[8];
    e.ram_a  = addr[7:0];
    e.din    = wd;
    e.exp_rd = 16'h0000;
    if (cmd == MREAD) begin
      if (!addr[8]) e.exp_rd = mem_model[addr[7:0]];
      else if (IO_EN && addr == 9'h140) e.exp_rd = {8'h00, sw};
    end
    if (cmd == MWRITE) begin
      if (!addr[8]) begin
        mem_model[addr[7:0]] = wd;
        exp_wr++;
      end else if (IO_EN && addr == 9'h100) begin
        led_model = wd[7:0];
      end
    end
    return e;
  endfunction

  function automatic void check_done(input int r);
    exp_t e;
    done_r.push_back(r);
    done_c.push_back(cyc);
    if (r == 0) begin
      chk("r0_done_has_txn", 32'(q0.size()), 32'd1);
      if (q0.size() == 0) return;
      e = q0.pop_front();
    end else begin
      chk("r1_done_has_txn", 32'(q1.size()), 32'd1);
      if (q1.size() == 0) return;
      e = q1.pop_front();
    end
    if (e.is_rd) begin
      chk($sformatf("r%0d_rdata", r), 32'(bus.rdata), 32'(e.exp_rd));
      last_exp = e.exp_rd;
    end else begin
      chk($sformatf("r%0d_rdata_hold", r), 32'(bus.rdata), 32'(last_exp));
    end
  endfunction

  // Monitor: completions, RAM write strobes and grant exclusivity
  always @(negedge clk) begin
    if (!reset) begin
      last_exp = 16'h0000;
    end else begin
      cyc++;
      chk("gnt_exclusive", 32'(bus.r0_gnt & bus.r1_gnt), 32'd0);
      if (ram_write) begin
        exp_t h;
        logic have;
        have = 1'b0;
        wr_cycles++;
        if (bus.r1_gnt && q1.size() > 0) begin
          h = q1[0];
          have = 1'b1;
        end else if (bus.r0_gnt && q0.size() > 0) begin
          h = q0[0];
          have = 1'b1;
        end
        chk("ram_write_owner", 32'(have), 32'd1);
        if (have) begin
          chk("ram_write_kind", 32'(h.ram_wr), 32'd1);
          chk("ram_addr", 32'(ram_addr), 32'(h.ram_a));
          chk("ram_din", 32'(ram_din), 32'(h.din));
        end
      end
      if (bus.r0_done) check_done(0);
      if (bus.r1_done) check_done(1);
    end
  end

  // One transaction; entered and left just after a rising edge
  task automatic txn(input int r, input logic [1:0] cmd, input logic [8:0] addr,
                     input logic [15:0] wd, output int lat, output int glat);
    exp_t e;
    logic g, d;
    e = model(cmd, addr, wd);
    if (r == 0) begin
      q0.push_back(e);
      bus.r0_cmd = cmd; bus.r0_addr = addr; bus.r0_wdata = wd; bus.r0_req = 1'b1;
    end else begin
      q1.push_back(e);
      bus.r1_cmd = cmd; bus.r1_addr = addr; bus.r1_wdata = wd; bus.r1_req = 1'b1;
    end
    lat = 99;
    glat = 99;
    for (int n = 1; n <= 12 && lat == 99; n++) begin
      @(negedge clk);
      g = (r == 0) ? bus.r0_gnt : bus.r1_gnt;
      d = (r == 0) ? bus.r0_done : bus.r1_done;
      if (glat == 99 && g) glat = n;
      if (d) lat = n;
    end
    chk($sformatf("r%0d_latency_le6 (lat=%0d)", r, lat), 32'(lat <= 6), 32'd1);
    @(posedge clk);
    #1;
    if (r == 0) bus.r0_req = 1'b0;
    else        bus.r1_req = 1'b0;
  endtask

  task automatic rand_driver(input int r, input int count);
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    int          sel, lat, glat;
    for (int i = 0; i < count; i++) begin
      cmd = 2'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 9));
      wd  = 16'($urandom);
      if (sel < 6) addr = {1'b0, 1'(r), 7'($urandom)};
      else if (sel == 6) addr = (r == 1) ? 9'h100 : 9'h1FF;
      else if (sel == 7) addr = 9'h140;
      else if (sel == 8) addr = (r == 1) ? 9'h1C0 : 9'h180;
      else addr = (r == 1) ? 9'h101 : 9'h141;
      txn(r, cmd, addr, wd, lat, glat);
      repeat (int'($urandom_range(0, 1))) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   base;
    logic seen;
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    bus.r0_cmd = MNONE; bus.r1_cmd = MNONE;
    bus.r0_addr = '0; bus.r1_addr = '0;
    bus.r0_wdata = '0; bus.r1_wdata = '0;
    sw = 8'hC3;
    led_model = 8'h00;
    last_exp = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 16'($urandom);
      mem_model[i] = ram_mem[i];
    end
    ram_mem[5] = 16'hABCD;
    mem_model[5] = 16'hABCD;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_r0_gnt", 32'(bus.r0_gnt), 32'd0);
    chk("rst_r1_gnt", 32'(bus.r1_gnt), 32'd0);
    chk("rst_done", 32'({bus.r0_done, bus.r1_done}), 32'd0);
    chk("rst_ram_write", 32'(ram_write), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_ledr", 32'(ledr), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Tie right after reset: r0 first, then strict alternation 3 cycles apart
    base = done_r.size();
    fork
      begin
        txn(0, MREAD, 9'h010, 16'h0, l0, g0);
        txn(0, MREAD, 9'h011, 16'h0, l0, g0);
      end
      begin
        txn(1, MREAD, 9'h090, 16'h0, l1, g1);
        txn(1, MREAD, 9'h091, 16'h0, l1, g1);
      end
    join
    chk("conflict_count", 32'(done_r.size() - base), 32'd4);
    if (done_r.size() - base == 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("conflict_order_%0d", k), 32'(done_r[base+k]), 32'(k % 2));
      for (int k = 0; k < 3; k++) chk($sformatf("conflict_gap_%0d", k), 32'(done_c[base+k+1] - done_c[base+k]), 32'd3);
    end

    // Solo read: grant one cycle after sampling, done the cycle after that
    txn(0, MREAD, 9'h005, 16'h0, l0, g0);
    chk("solo_gnt_cycle", 32'(g0), 32'd2);
    chk("solo_done_cycle", 32'(l0), 32'd3);

    txn(1, MWRITE, 9'h100, 16'h005A, l1, g1);
    chk("led_write", 32'(ledr), 32'(led_model));
    txn(1, MREAD, 9'h140, 16'h0, l1, g1);

    txn(0, MWRITE, 9'h1FF, 16'hBEEF, l0, g0);
    txn(0, MNONE, 9'h000, 16'h1234, l0, g0);
    chk("led_after_unmapped", 32'(ledr), 32'(led_model));
    txn(0, MWRITE, 9'h020, 16'h1357, l0, g0);
    txn(1, MREAD, 9'h020, 16'h0, l1, g1);

    // Reset during the access cycle of an LED write
    bus.r1_cmd = MWRITE; bus.r1_addr = 9'h100; bus.r1_wdata = 16'h0077; bus.r1_req = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      seen = bus.r1_gnt;
    end
    chk("rstop_gnt_seen", 32'(seen), 32'd1);
    reset = 1'b0;
    led_model = 8'h00;
    #1;
    chk("rstop_gnt", 32'({bus.r0_gnt, bus.r1_gnt}), 32'd0);
    chk("rstop_done", 32'({bus.r0_done, bus.r1_done}), 32'd0);
    chk("rstop_ram_write", 32'(ram_write), 32'd0);
    chk("rstop_ledr", 32'(ledr), 32'd0);
    bus.r1_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rstop_ledr_after", 32'(ledr), 32'(led_model));
    chk("rstop_rdata_after", 32'(bus.rdata), 32'd0);

    sw = 8'($urandom);
    fork
      rand_driver(0, 40);
      rand_driver(1, 40);
    join

    for (int n = 0; n < 20 && (q0.size() + q1.size()) != 0; n++) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("ram_write_cycles", 32'(wr_cycles), 32'(exp_wr));
    chk("ledr_final", 32'(ledr), 32'(led_model));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 256×16 RAM and the memory-mapped I/O (LEDs, switches) between two requesters: requester 0 (the CPU) and requester 1 (a debug/program loader). The block sits between the requesters' `mem_cmd`/`mem_addr` buses and the RAM, and replaces the top-level glue decode. It handles round-robin arbitration, address decode, RAM read latency and the LED output register.

## Interface
Parameters:
- `AW`, 9: requester address width.
- `DW`, 16: data width.
- `RAM_AW`, 8: RAM address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `r0_req`, `r1_req`  in  1  request; held high, with cmd/addr/wdata stable, until `done` is seen.
- `r0_cmd`, `r1_cmd`  in  2  `MNONE`=00, `MREAD`=01, `MWRITE`=10.
- `r0_addr`, `r1_addr`  in  AW  byte-free word address.
- `r0_wdata`, `r1_wdata`  in  DW  write data.
- `r0_gnt`, `r1_gnt`  out  1  owner of the current transaction (registered).
- `r0_done`, `r1_done`  out  1  one-cycle completion pulse (registered).
- `rdata`  out  DW  read result; shared by both requesters, qualified by that requester's `done`.
- `ram_addr`  out  RAM_AW  RAM address.
- `ram_write`  out  1  RAM write strobe.
- `ram_din`  out  DW  RAM write data.
- `ram_dout`  in  DW  RAM read data; registered read, valid one cycle after the address.
- `sw`  in  8  switch inputs.
- `ledr`  out  8  LED register.

## Operation
- FSM states: `IDLE` → `ACC` → `RSP` → `IDLE`.
- **IDLE**
  - Samples requests.
  - If any `req` is high: latches the winner's cmd/addr/wdata, sets that requester's `gnt`, and goes to `ACC`.
  - Round-robin: when both requests are high, the requester not granted last wins. The last-granted pointer resets to 1, so `r0` wins the first tie.
- **ACC**
  - `ram_addr` = latched addr[7:0] and `ram_din` = latched wdata.
  - `ram_write` = 1 only when cmd is `MWRITE` and addr[8]=0.
  - Always goes to `RSP`.
- **RSP**
  - Owner's `done` = 1.
  - `rdata` is loaded at the ACC→RSP edge:
    - addr[8]=0 and `MREAD`: `ram_dout`.
    - addr = 0x140 and `MREAD`: `{8'h00, sw}`.
    - Any other read: 16'h0000.
  - `rdata` holds until the next read completes.
  - `ledr` loads wdata[7:0] at the ACC→RSP edge when cmd is `MWRITE` and addr = 0x100.
  - Writes to other unmapped addresses are dropped, and `done` still pulses.
  - `MNONE` with `req` high is a no-op transaction that still completes with `done`.
  - `gnt` drops and the FSM returns to `IDLE`.
- Back-to-back: a `req` still high in the `IDLE` cycle after `done` starts a new transaction, subject to round-robin. A requester wanting exactly one access drops `req` on the edge at which it samples `done`.

## Timing
- Reset values: state `IDLE`; all `gnt`/`done` 0; `rdata` 0; `ledr` 0; `ram_write` 0; `ram_addr`/`ram_din` 0; pointer 1.
- Latency: request sampled at edge E0; `done` high from E1 to E2. An access takes 3 cycles (IDLE, ACC, RSP) and the maximum throughput is 1 access per 3 cycles.
- `ram_write` is high for exactly one cycle (ACC) per write.
- Starvation bound: a continuously asserted request completes within 6 cycles of its first sampling.
- Reset asserted mid-transaction clears all outputs immediately. No write completes unless `ram_write` has already been sampled by the RAM. `ledr` is cleared.
- A `req` deasserted while granted is a protocol violation. The latched transaction still completes.

## Configuration
- `MEM_ARBITER_IO_EN`
  - Defined: the LED register (0x100) and switch read (0x140) are present.
  - Undefined: every address with addr[8]=1 is unmapped (reads return 0, writes are dropped), `ledr` is tied to 0, and `sw` is unused.

## Structure
- Package `mem_arb_pkg` contains:
  - `MNONE`/`MREAD`/`MWRITE` constants.
  - The `state_t` enum (`IDLE`, `ACC`, `RSP`).
  - `LED_ADDR`=9'h100 and `SW_ADDR`=9'h140.
- Sub-module `mem_io_regs` holds the address decode, the LED register and the switch read mux. It is instantiated only under `MEM_ARBITER_IO_EN`.

## Test plan
- **Solo read:** RAM[0x05]=16'hABCD preloaded; `r0` reads 0x005. Expect `r0_gnt` at E0+1, `r0_done` one cycle at E1+1, `rdata`=16'hABCD, `ram_write` never high.
- **Conflict:** `r0` and `r1` both assert at the same edge after reset. Expect order `r0`, `r1`, `r0`, `r1` under continuous requests, each `done` 3 cycles apart.
- **I/O:** `r1` writes 16'h005A to 0x100, giving `ledr`=8'h5A. With `sw`=8'hC3, a read of 0x140 gives `rdata`=16'h00C3. Without the macro, the same read gives 16'h0000 and `ledr` stays 0.
- **Unmapped/MNONE:** write to 0x1FF and `MNONE` to 0x000. Expect `done` pulses, no `ram_write`, `ledr` unchanged.
- **Reset mid-op:** assert `reset` low during `ACC` of a write to 0x100. Expect immediate `IDLE`, `gnt`/`done`/`ram_write` 0, and `ledr` 0 after release.
